// File: rtl/bcd_countdown_ctrl.sv
// Countdown control ahead of the display scanner: debounced start/clear keys, IDLE/RUN/PAUSE/DONE
// control and a 4-digit BCD down-counter. Define BCD_COUNTDOWN_BLINK_EN to blink blank in DONE.
module bcd_countdown_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_clr,
    input  logic [15:0] preset,
    output logic [15:0] count,
    output logic        running,
    output logic        done,
    output logic        tick,
    output logic        blank
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);

    if (TICK_DIV < 2 || DEB_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_chk
        $error("bcd_countdown_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

    // Key path: bit 0 = start, bit 1 = clear. Levels are active-low, so 1 = released.
    logic [1:0]         key_pin;
    logic [1:0]         sync1_q, sync2_q, acc_q, acc_d, press_q;
    logic [1:0][DW-1:0] deb_q, deb_d;

    assign key_pin = {key_clr, key_start};

    always_comb begin
        acc_d = acc_q;
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DW'(DEB_CYCLES - 1)) begin
                deb_d[i] = '0;
                acc_d[i] = sync2_q[i];
            end else begin
                deb_d[i] = deb_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            acc_q   <= '1;
            deb_q   <= '0;
            press_q <= '0;
        end else begin
            sync1_q <= key_pin;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            deb_q   <= deb_d;
            press_q <= acc_q & ~acc_d;
        end
    end

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        return r;
    endfunction

    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [15:0]     count_q, count_d, preset_cl, count_dec;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_q, tick_d, running_q, done_q;
    logic            start_p, clr_p, wrap;

    assign start_p   = press_q[0];
    assign clr_p     = press_q[1];
    assign preset_cl = clamp_bcd(preset);
    assign count_dec = dec_bcd(count_q);
    assign wrap      = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d = preset_cl;
                presc_d = '0;
                if (start_p) state_d = (preset_cl == 16'h0000) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (wrap) begin
                    tick_d  = 1'b1;
                    count_d = count_dec;
                end
                // Reaching zero outranks a same-cycle pause request.
                if (wrap && count_dec == 16'h0000) state_d = S_DONE;
                else if (start_p)                  state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (start_p) state_d = S_RUN;
            end
            S_DONE: begin
                count_d = '0;
                presc_d = '0;
                if (start_p) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Clear wins over everything; the count reloads once IDLE is reached.
        if (clr_p) begin
            state_d = S_IDLE;
            tick_d  = 1'b0;
            presc_d = '0;
            if (state_q != S_IDLE) count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign tick    = tick_q;

`ifdef BCD_COUNTDOWN_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic          blank_q, blank_d;
    logic [BW-1:0] blink_q, blink_d;

    always_comb begin
        blank_d = 1'b0;
        blink_d = '0;
        if (state_d == S_DONE) begin
            if (state_q != S_DONE) begin
                blank_d = 1'b1;
            end else if (blink_q == BW'(BLINK_DIV - 1)) begin
                blank_d = ~blank_q;
            end else begin
                blank_d = blank_q;
                blink_d = blink_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= 1'b0;
            blink_q <= '0;
        end else begin
            blank_q <= blank_d;
            blink_q <= blink_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: doc/bcd_countdown_ctrl.md
# bcd_countdown_ctrl

Countdown control stage that sits directly upstream of the six-digit multiplexed display scanner. It debounces two push-buttons, runs a start/pause/clear state machine, and decrements a four-digit BCD count on a divided tick. It presents the count and status as stable registered values for the scanner to decode and show.

## Interface

Parameters:
- TICK_DIV, 50000: clk cycles per count decrement (1 kHz at 50 MHz); must be ≥ 2.
- DEB_CYCLES, 1000000: consecutive stable synchronized samples required to accept a key level (20 ms at 50 MHz); must be ≥ 1.
- BLINK_DIV, 12500000: clk cycles per blank toggle in DONE; used only with blink compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_start  in  1  start/pause button, active-low, asynchronous to clk.
- key_clr  in  1  clear button, active-low, asynchronous to clk.
- preset  in  16  four BCD digits, [15:12] most significant; treated as quasi-static.
- count  out  16  current four-digit BCD value, same layout as preset.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- tick  out  1  one-cycle pulse on each decrement event.
- blank  out  1  display blank request; the scanner forces all segments off while high.

## Operation

- Key path, per key: 2-FF synchronizer, then debounce. A counter runs while the synchronized level differs from the accepted level and clears when they match. The accepted level updates when the counter reaches DEB_CYCLES. An accepted 1→0 transition gives a one-cycle press pulse. Release produces no event.
- Accepted levels reset to 1 (released). Debounce counters reset to 0.
- States: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- IDLE: count <= clamp(preset) every cycle. Clamp replaces any nibble >9 with 9. On start press: if clamp(preset)==0, go to DONE; otherwise go to RUN with the prescaler cleared to 0.
- RUN: the prescaler counts 0..TICK_DIV-1. At wrap, tick pulses, and count decrements as 4-digit BCD with borrow (x0→x9, borrow into the next nibble). If the decremented value is 0000, go to DONE on the same edge. Start press goes to PAUSE.
- PAUSE: prescaler and count are held. Start press returns to RUN, and the prescaler phase is preserved.
- DONE: count is held at 0000. Start press goes to IDLE.
- Clear press from any state goes to IDLE. Count reloads on the following cycle.
- Clear and start presses in the same cycle: clear wins.
- A tick wrap and a start press in the same RUN cycle: the decrement happens and the state goes to PAUSE. If the decrement reaches 0000, DONE takes priority over PAUSE.
- Count never underflows. Decrement occurs only in RUN, and RUN is never entered with count 0000.

## Timing

- Reset values: count=0000, running=0, done=0, tick=0, blank=0, prescaler=0, state=IDLE.
- count shows clamp(preset) from the second clk edge after reset release. It tracks preset changes in IDLE with 1-cycle latency.
- Key latency: a clean press gives its pulse 2 (sync) + DEB_CYCLES cycles after the pin falls. The state changes on the edge that samples the pulse, and running/done update in the same cycle.
- Bounce: any glitch shorter than DEB_CYCLES cycles produces no pulse.
- First tick after entering RUN from IDLE: TICK_DIV cycles later. After that, one tick every TICK_DIV cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset may be asserted at any time, including mid-debounce and mid-count. All state returns to reset values asynchronously, and no spurious press pulse is generated after release.

## Configuration

- BCD_COUNTDOWN_BLINK_EN defined: in DONE, blank toggles every BLINK_DIV cycles, starting at 1 on DONE entry. On leaving DONE, blank is 0 and the blink counter is 0 within one cycle.
- Macro undefined: blank is tied to 0, and the blink counter and BLINK_DIV logic are absent.

## Test plan

Bench parameters: TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=5.

- Reset, preset=0x0012 → count=0x0012 after 2 edges. Start press → running=1, count 0x0011 at the 4th cycle after entry, then 0x0010, then 0x0009 (borrow). done=1 on the 0x0000 edge, with running=0.
- Bounce: key_start low for 2 cycles, high 1, low 2, then released → no state change. A 5-cycle clean low → exactly one RUN entry.
- Pause: RUN with count 0x0100, start press → PAUSE, count held for 20 cycles. Start again → first tick comes after the remaining prescaler phase, not a full TICK_DIV.
- Clear priority: same-cycle start and clear pulses in RUN → IDLE, count=clamp(preset) next cycle. preset=0x9A0F loads 0x9909.
- Zero preset: preset=0x0000, start press → DONE directly, no tick. Start again → IDLE.
- With BCD_COUNTDOWN_BLINK_EN: in DONE, blank=1 for 5 cycles, 0 for 5, repeating. Clear → blank=0 next cycle. Without the macro: blank stays 0 throughout.
